// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: FSM state encodings
// and the default opcode used to mark a bubble.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [3:0] PIPE_NOP_OP = 4'b1011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: advances by one on each cycle with inc high and then
// sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline stage with registered in_ready, bubble
// insertion on empty, synchronous flush and a saturating backpressure counter.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int              DATA_W = 64,
  parameter int              OP_W   = 4,
  parameter logic [OP_W-1:0] NOP_OP = OP_W'(PIPE_NOP_OP),
  parameter int              CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OP_W-1:0]   in_op,
  input  logic              in_invalid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OP_W-1:0]   out_op,
  output logic              out_invalid,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            r_state, w_state_next;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_main_data, w_main_data_next;
  logic [OP_W-1:0]   r_main_op, w_main_op_next;
  logic              r_main_inv, w_main_inv_next;
  logic [DATA_W-1:0] r_skid_data, w_skid_data_next;
  logic [OP_W-1:0]   r_skid_op, w_skid_op_next;
  logic              r_skid_inv, w_skid_inv_next;

  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;
  logic w_stall;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;
  assign w_stall     = w_out_valid & ~out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_main_data_next = r_main_data;
    w_main_op_next   = r_main_op;
    w_main_inv_next  = r_main_inv;
    w_skid_data_next = r_skid_data;
    w_skid_op_next   = r_skid_op;
    w_skid_inv_next  = r_skid_inv;

    if (flush) begin
      w_state_next     = ST_EMPTY;
      w_main_data_next = '0;
      w_main_op_next   = NOP_OP;
      w_main_inv_next  = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_next     = ST_ONE;
            w_main_data_next = in_data;
            w_main_op_next   = in_op;
            w_main_inv_next  = in_invalid;
          end else begin
            // Bubble keeps the previous invalid flag on purpose.
            w_main_data_next = '0;
            w_main_op_next   = NOP_OP;
          end
        end
        ST_ONE: begin
          case ({w_in_fire, w_out_fire})
            2'b10: begin
              w_state_next     = ST_FULL;
              w_skid_data_next = in_data;
              w_skid_op_next   = in_op;
              w_skid_inv_next  = in_invalid;
            end
            2'b01: begin
              w_state_next     = ST_EMPTY;
              w_main_data_next = '0;
              w_main_op_next   = NOP_OP;
            end
            2'b11: begin
              w_main_data_next = in_data;
              w_main_op_next   = in_op;
              w_main_inv_next  = in_invalid;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          // in_ready is low while FULL, so only the drain case exists here.
          if (w_out_fire) begin
            w_state_next     = ST_ONE;
            w_main_data_next = r_skid_data;
            w_main_op_next   = r_skid_op;
            w_main_inv_next  = r_skid_inv;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b0;
      r_main_data <= '0;
      r_main_op   <= NOP_OP;
      r_main_inv  <= 1'b0;
      r_skid_data <= '0;
      r_skid_op   <= '0;
      r_skid_inv  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next != ST_FULL);
      r_main_data <= w_main_data_next;
      r_main_op   <= w_main_op_next;
      r_main_inv  <= w_main_inv_next;
      r_skid_data <= w_skid_data_next;
      r_skid_op   <= w_skid_op_next;
      r_skid_inv  <= w_skid_inv_next;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_stall),
    .count(stall_cnt)
  );

  assign in_ready    = r_in_ready;
  assign out_valid   = w_out_valid;
  assign out_data    = r_main_data;
  assign out_op      = r_main_op;
  assign out_invalid = r_main_inv;
  assign occupancy   = r_state;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: reset, streaming, backpressure, flush,
// counter saturation and asynchronous reset, each with hand-computed values.
module tb_pipe_skid_stage;

  localparam int DATA_W = 64;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [OP_W-1:0]   in_op;
  logic              in_invalid;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [OP_W-1:0]   out_op;
  logic              out_invalid;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int tests_run;
  int tests_failed;

  localparam logic [DATA_W-1:0] DA = 64'h0000_0000_0000_00A1;
  localparam logic [DATA_W-1:0] DB = 64'h0000_0000_0000_00B2;
  localparam logic [DATA_W-1:0] DC = 64'h0000_0000_0000_00C3;
  localparam logic [DATA_W-1:0] DD = 64'h0000_0000_0000_00D4;

  pipe_skid_stage #(
    .DATA_W(DATA_W),
    .OP_W  (OP_W),
    .NOP_OP(4'b1011),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_op      (in_op),
    .in_invalid (in_invalid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_op     (out_op),
    .out_invalid(out_invalid),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    rst        = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_op      = '0;
    in_invalid = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #4;
  endtask

  // Releases reset mid-cycle and takes the first edge (which only raises in_ready).
  task automatic reset_and_release();
    hold_reset();
    rst = 1'b1;
    step();
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic [OP_W-1:0] op, input logic inv);
    in_valid   = 1'b1;
    in_data    = d;
    in_op      = op;
    in_invalid = inv;
  endtask

  task automatic test_reset();
    hold_reset();
    in_valid = 1'b1; in_data = 64'h1234; in_op = 4'h2;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    tests_run++; if (out_data !== 64'h0) begin tests_failed++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    tests_run++; if (out_op !== 4'hB) begin tests_failed++; $display("FAIL rst_out_op: got %h want b", out_op); end
    tests_run++; if (out_invalid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_invalid: got %b want 0", out_invalid); end
    tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
    tests_run++; if (stall_cnt !== 4'd0) begin tests_failed++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
    rst = 1'b1;
    step();
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rel_edge1_in_ready: got %b want 1", in_ready); end
    tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL rel_edge1_no_accept: got %0d want 0", occupancy); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rel_edge1_out_valid: got %b want 0", out_valid); end
    step();
    in_valid = 1'b0;
    tests_run++; if (out_data !== 64'h1234) begin tests_failed++; $display("FAIL rel_edge2_data: got %h want 1234", out_data); end
    tests_run++; if (out_op !== 4'h2) begin tests_failed++; $display("FAIL rel_edge2_op: got %h want 2", out_op); end
    tests_run++; if (occupancy !== 2'd1) begin tests_failed++; $display("FAIL rel_edge2_occupancy: got %0d want 1", occupancy); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] exp_d [3];
    logic [OP_W-1:0]   exp_o [3];
    exp_d[0] = DA; exp_d[1] = DB; exp_d[2] = DC;
    exp_o[0] = 4'h1; exp_o[1] = 4'h2; exp_o[2] = 4'h3;
    reset_and_release();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(exp_d[i], exp_o[i], 1'b0);
      step();
      tests_run++; if (out_data !== exp_d[i]) begin tests_failed++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, exp_d[i]); end
      tests_run++; if (out_op !== exp_o[i]) begin tests_failed++; $display("FAIL stream_op[%0d]: got %h want %h", i, out_op, exp_o[i]); end
      tests_run++; if (occupancy !== 2'd1) begin tests_failed++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occupancy); end
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL stream_drain_occ: got %0d want 0", occupancy); end
    tests_run++; if (out_op !== 4'hB) begin tests_failed++; $display("FAIL stream_bubble_op: got %h want b", out_op); end
    tests_run++; if (out_data !== 64'h0) begin tests_failed++; $display("FAIL stream_bubble_data: got %h want 0", out_data); end
    $display("[TB] test_stream done");
  endtask

  task automatic test_backpressure();
    reset_and_release();
    send(DA, 4'h1, 1'b0);
    step();
    send(DB, 4'h2, 1'b0);
    step();
    in_valid = 1'b0;
    tests_run++; if (occupancy !== 2'd2) begin tests_failed++; $display("FAIL bp_full_occ: got %0d want 2", occupancy); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full_in_ready: got %b want 0", in_ready); end
    for (int i = 1; i <= 3; i++) begin
      tests_run++; if (out_data !== DA) begin tests_failed++; $display("FAIL bp_hold_data[%0d]: got %h want %h", i, out_data, DA); end
      tests_run++; if (stall_cnt !== 4'(i)) begin tests_failed++; $display("FAIL bp_stall[%0d]: got %0d want %0d", i, stall_cnt, i); end
      if (i < 3) step();
    end
    out_ready = 1'b1;
    step();
    tests_run++; if (out_data !== DB) begin tests_failed++; $display("FAIL bp_second_data: got %h want %h", out_data, DB); end
    tests_run++; if (occupancy !== 2'd1) begin tests_failed++; $display("FAIL bp_second_occ: got %0d want 1", occupancy); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_in_ready_back: got %b want 1", in_ready); end
    tests_run++; if (stall_cnt !== 4'd3) begin tests_failed++; $display("FAIL bp_stall_freeze: got %0d want 3", stall_cnt); end
    step();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_flush();
    reset_and_release();
    send(DA, 4'h1, 1'b0);
    step();
    send(DB, 4'h2, 1'b0);
    step();
    flush = 1'b1;
    send(DC, 4'h3, 1'b0);
    step();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    tests_run++; if (out_op !== 4'hB) begin tests_failed++; $display("FAIL flush_out_op: got %h want b", out_op); end
    tests_run++; if (out_invalid !== 1'b1) begin tests_failed++; $display("FAIL flush_out_invalid: got %b want 1", out_invalid); end
    tests_run++; if (out_data !== 64'h0) begin tests_failed++; $display("FAIL flush_out_data: got %h want 0", out_data); end
    tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    tests_run++; if (stall_cnt !== 4'd2) begin tests_failed++; $display("FAIL flush_stall_kept: got %0d want 2", stall_cnt); end
    send(DD, 4'h4, 1'b0);
    step();
    tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL flush_discard_occ: got %0d want 0", occupancy); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_no_ghost: got %b want 0", out_valid); end
    tests_run++; if (out_invalid !== 1'b1) begin tests_failed++; $display("FAIL flush_bubble_invalid: got %b want 1", out_invalid); end
    tests_run++; if (out_data !== 64'h0) begin tests_failed++; $display("FAIL flush_bubble_data: got %h want 0", out_data); end
    $display("[TB] test_flush done");
  endtask

  task automatic test_saturate();
    logic [CNT_W-1:0] exp_cnt;
    reset_and_release();
    send(DA, 4'h5, 1'b1);
    step();
    in_valid = 1'b0;
    tests_run++; if (out_invalid !== 1'b1) begin tests_failed++; $display("FAIL sat_invalid_pass: got %b want 1", out_invalid); end
    for (int i = 1; i <= 20; i++) begin
      step();
      exp_cnt = (i > 15) ? 4'd15 : 4'(i);
      tests_run++; if (stall_cnt !== exp_cnt) begin tests_failed++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, stall_cnt, exp_cnt); end
      tests_run++; if (out_data !== DA || out_op !== 4'h5) begin tests_failed++; $display("FAIL sat_stable[%0d]: got %h/%h want %h/5", i, out_data, out_op, DA); end
    end
    $display("[TB] test_saturate done");
  endtask

  task automatic test_async_reset();
    reset_and_release();
    send(DA, 4'h1, 1'b0);
    step();
    send(DB, 4'h2, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    tests_run++; if (occupancy !== 2'd2 || stall_cnt !== 4'd2) begin tests_failed++; $display("FAIL arst_pre: got occ %0d cnt %0d want 2 2", occupancy, stall_cnt); end
    #3 rst = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
    tests_run++; if (out_op !== 4'hB) begin tests_failed++; $display("FAIL arst_out_op: got %h want b", out_op); end
    tests_run++; if (stall_cnt !== 4'd0) begin tests_failed++; $display("FAIL arst_stall_cnt: got %0d want 0", stall_cnt); end
    tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL arst_occ: got %0d want 0", occupancy); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL arst_in_ready: got %b want 0", in_ready); end
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_op        = '0;
    in_invalid   = 1'b0;
    out_ready    = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
